uart_cmd_wrapper: RTL and testbench
===================================

UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 SHALL have parameter BAUD_CNT, default 2604, clocks per UART bit (50 MHz / 19200).
REQ-002 SHALL have parameter FRAME_TO, default 65535, maximum idle clocks between bytes of one command frame.
REQ-003 SHALL have port clk  input  1  single system clock; all state rises on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port RX  input  1  serial input from CommMaster, idle high, asynchronous to clk.
REQ-006 SHALL have port TX  output  1  serial response output to CommMaster, idle high.
REQ-007 SHALL have port cmd  output  8  opcode of the last complete frame.
REQ-008 SHALL have port data  output  16  payload of the last complete frame.
REQ-009 SHALL have port cmd_rdy  output  1  a complete frame is held in cmd/data.
REQ-010 SHALL have port clr_cmd_rdy  input  1  consumer acknowledge that clears cmd_rdy.
REQ-011 SHALL have port resp  input  8  response byte to transmit.
REQ-012 SHALL have port send_resp  input  1  single-cycle request to transmit resp.
REQ-013 SHALL have port tx_busy  output  1  transmitter is shifting a byte.
REQ-014 SHALL have port resp_sent  output  1  last requested response byte has fully left TX.

Function
REQ-015 Serial format SHALL be 8N1, LSB first; each bit lasts exactly BAUD_CNT clocks.
REQ-016 RX SHALL pass through a two-flop synchronizer (set to 1 on reset) before any use.
REQ-017 Receiver FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START on a synchronized falling edge.
REQ-018 START SHALL sample at BAUD_CNT/2 clocks; sample 1 -> false start, return to IDLE with no byte.
REQ-019 DATA SHALL take 8 samples spaced BAUD_CNT clocks apart, shifting LSB first.
REQ-020 STOP sample 1 SHALL deliver the byte to the framer; sample 0 (framing error) SHALL discard the byte and reset the framer to byte 0.
REQ-021 Framer SHALL assemble byte 0 -> cmd, byte 1 -> data[15:8], byte 2 -> data[7:0]; cmd/data update together only after byte 2.
REQ-022 cmd_rdy SHALL assert on the clock after byte 2's stop sample and stay high until cleared.
REQ-023 cmd_rdy SHALL clear on clr_cmd_rdy, or on the start edge of a subsequent frame's byte 0.
REQ-024 Frame completion and clr_cmd_rdy in the same cycle SHALL leave cmd_rdy = 1 (set wins).
REQ-025 cmd and data SHALL hold their values until the next complete frame, independent of cmd_rdy.
REQ-026 Gap counter SHALL run while the framer index is nonzero and the receiver is IDLE; reaching FRAME_TO SHALL drop the partial frame (index -> 0, no cmd_rdy).
REQ-027 Transmitter FSM states SHALL be IDLE, START, DATA, STOP; send_resp in IDLE SHALL latch resp and drive TX low on the next clock.
REQ-028 tx_busy SHALL be 1 from the first start-bit clock through the last stop-bit clock (10*BAUD_CNT clocks).
REQ-029 send_resp while tx_busy SHALL be ignored; the byte in flight is unaffected.
REQ-030 resp_sent SHALL clear on an accepted send_resp and set on the clock after the stop bit ends, holding until the next accepted send_resp.
REQ-031 Receive and transmit paths SHALL operate fully concurrently.

Reset
REQ-032 While rst = 1: TX = 1, cmd = 8'h00, data = 16'h0000, cmd_rdy = 0, tx_busy = 0, resp_sent = 0, both FSMs IDLE, framer index 0, all counters 0.
REQ-033 Reset asserted mid-byte or mid-frame SHALL abandon it; after release the first valid start bit SHALL begin a new byte 0.

Verification (BAUD_CNT = 16, FRAME_TO = 200)
REQ-034 Bytes 8'h05, 8'hA5, 8'h3C sent -> cmd = 8'h05, data = 16'hA53C, cmd_rdy high one clock after third stop sample.
REQ-035 clr_cmd_rdy pulsed in the same cycle as frame completion -> cmd_rdy = 1; pulsed one cycle later -> cmd_rdy = 0, cmd/data unchanged.
REQ-036 Two bytes sent, 300-clock idle, then 8'h02, 8'h12, 8'h34 -> cmd = 8'h02, data = 16'h1234; no cmd_rdy before third byte.
REQ-037 Byte with stop bit 0 as byte 1 of a frame -> frame dropped; next full frame decodes correctly.
REQ-038 send_resp with resp = 8'hA5 -> TX low next clock, bits 1,0,1,0,0,1,0,1 each 16 clocks, tx_busy high 160 clocks, resp_sent set after; second send_resp mid-byte ignored.
REQ-039 rst pulsed mid-frame -> all outputs at REQ-032 values; following full frame decodes correctly.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// UART command front end: 8N1 receiver feeding a 3-byte command framer
// (opcode, data hi, data lo) plus an independent single-byte response transmitter.
module uart_cmd_wrapper #(
    parameter int BAUD_CNT = 2604,
    parameter int FRAME_TO = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent
);
    localparam int CNT_W = $clog2(BAUD_CNT) + 1;
    localparam int GAP_W = $clog2(FRAME_TO + 1) + 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_CNT / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(FRAME_TO - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic             rx_p0, rx_p1, rx_p2;
    state_t           rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             vld_p0, ferr_p0;
    logic [1:0]       idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       cmd_buf, data_hi;
    state_t           tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;

    logic rx_fall, frame_start, gap_run, gap_to;

    assign rx_fall     = rx_p2 & ~rx_p1;
    assign frame_start = (rx_state == S_IDLE) && rx_fall && (idx == 2'd0);
    assign gap_run     = (idx != 2'd0) && (rx_state == S_IDLE);
    assign gap_to      = gap_run && (gap_cnt == GAP_END);

    // Stage p0..p1 synchronize RX; p2 is the previous synchronized value for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= RX;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            vld_p0   <= 1'b0;
            ferr_p0  <= 1'b0;
        end else begin
            vld_p0  <= 1'b0;
            ferr_p0 <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_fall) rx_state <= S_START;
                end
                S_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_p1 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                        vld_p0   <= rx_p1;
                        ferr_p0  <= ~rx_p1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers; their contents only matter once the matching control says so.
    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_cnt == BIT_END) rx_shift <= {rx_p1, rx_shift[7:1]};
        if (vld_p0 && idx == 2'd0) cmd_buf <= rx_shift;
        if (vld_p0 && idx == 2'd1) data_hi <= rx_shift;
        if (tx_state == S_IDLE && send_resp) tx_shift <= resp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            gap_cnt <= '0;
            cmd     <= '0;
            data    <= '0;
            cmd_rdy <= 1'b0;
        end else begin
            if (vld_p0) begin
                gap_cnt <= '0;
                case (idx)
                    2'd0:    idx <= 2'd1;
                    2'd1:    idx <= 2'd2;
                    default: begin
                        idx  <= 2'd0;
                        cmd  <= cmd_buf;
                        data <= {data_hi, rx_shift};
                    end
                endcase
            end else if (ferr_p0 || gap_to) begin
                idx     <= '0;
                gap_cnt <= '0;
            end else if (gap_run) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            // Completion takes priority over any clear in the same cycle.
            if (vld_p0 && idx == 2'd2) cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || frame_start) cmd_rdy <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            TX        <= 1'b1;
            tx_busy   <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (send_resp) begin
                        tx_state  <= S_START;
                        tx_cnt    <= '0;
                        TX        <= 1'b0;
                        tx_busy   <= 1'b1;
                        resp_sent <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        TX       <= tx_shift[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            TX       <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            TX     <= tx_shift[tx_bit + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt    <= '0;
                        tx_state  <= S_IDLE;
                        tx_busy   <= 1'b0;
                        resp_sent <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed + randomized bench for uart_cmd_wrapper with a byte-queue frame model
// and a mid-bit serial decoder for the response transmitter.
module tb_uart_cmd_wrapper;
    localparam int BAUD = 16;
    localparam int FTO  = 200;

    logic        clk = 1'b0;
    logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, tx_busy, resp_sent;
    logic [7:0]  cmd, resp;
    logic [15:0] data;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_cmd  = 8'h00;
    logic [15:0] exp_data = 16'h0000;
    logic        exp_rdy  = 1'b0;
    logic [7:0]  part[$];

    always #5 clk = ~clk;

    uart_cmd_wrapper #(.BAUD_CNT(BAUD), .FRAME_TO(FTO)) dut (
        .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
        .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
        .send_resp(send_resp), .tx_busy(tx_busy), .resp_sent(resp_sent)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_rx(input logic v, input int n);
        RX = v;
        repeat (n) @(negedge clk);
    endtask

    // Serializes one byte; the model is updated from the byte-level rules only.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic last,
                             input logic clr_hold);
        logic early;
        early = 1'b0;
        if (part.size() == 0) exp_rdy = 1'b0;
        hold_rx(1'b0, BAUD);
        for (int i = 0; i < 8; i++) hold_rx(b[i], BAUD);
        RX = stop;
        clr_cmd_rdy = clr_hold;
        for (int i = 1; i <= BAUD; i++) begin
            @(negedge clk);
            if (i == BAUD / 2) early = cmd_rdy;
            if (clr_cmd_rdy && cmd_rdy) clr_cmd_rdy = 1'b0;
        end
        clr_cmd_rdy = 1'b0;
        RX = 1'b1;
        if (!stop) begin
            part.delete();
        end else begin
            part.push_back(b);
            if (part.size() == 3) begin
                exp_cmd  = part[0];
                exp_data = {part[1], part[2]};
                exp_rdy  = 1'b1;
                part.delete();
            end
        end
        if (last) begin
            check("rdy_before_stop_sample", early, 0);
            check("cmd_rdy_after_frame", cmd_rdy, exp_rdy);
            check("cmd_after_frame", cmd, exp_cmd);
            check("data_after_frame", data, exp_data);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic clr_hold);
        send_byte(b0, 1'b1, 1'b0, 1'b0);
        send_byte(b1, 1'b1, 1'b0, 1'b0);
        send_byte(b2, 1'b1, 1'b1, clr_hold);
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        check("cmd_rdy_cleared", cmd_rdy, 0);
        check("cmd_kept_on_clr", cmd, exp_cmd);
        check("data_kept_on_clr", data, exp_data);
    endtask

    // Sends r and decodes TX at the middle of each bit period.
    task automatic tx_byte(input logic [7:0] r, input logic inject);
        logic [7:0] got;
        got = 8'h00;
        resp = r;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("tx_low_next_clock", TX, 0);
        check("tx_busy_start", tx_busy, 1);
        check("resp_sent_cleared", resp_sent, 0);
        repeat (BAUD / 2) @(negedge clk);
        check("tx_start_bit", TX, 0);
        for (int i = 0; i < 8; i++) begin
            if (inject && i == 3) begin
                resp = ~r;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
                repeat (BAUD - 1) @(negedge clk);
            end else begin
                repeat (BAUD) @(negedge clk);
            end
            got[i] = TX;
        end
        check("tx_decoded_byte", got, r);
        repeat (BAUD) @(negedge clk);
        check("tx_stop_bit", TX, 1);
        repeat (BAUD / 2 - 1) @(negedge clk);
        check("tx_busy_last_clock", tx_busy, 1);
        check("resp_sent_while_busy", resp_sent, 0);
        @(negedge clk);
        check("tx_busy_done", tx_busy, 0);
        check("resp_sent_set", resp_sent, 1);
        check("tx_idle_high", TX, 1);
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        resp = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_tx", TX, 1);
        check("reset_cmd", cmd, 0);
        check("reset_data", data, 0);
        check("reset_cmd_rdy", cmd_rdy, 0);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_resp_sent", resp_sent, 0);
        rst = 1'b0;
        hold_rx(1'b1, 2 * BAUD);

        // Basic frame decode.
        send_frame(8'h05, 8'hA5, 8'h3C, 1'b0);

        // Clear coinciding with completion loses; a later clear wins.
        r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
        send_frame(r0, r1, r2, 1'b1);
        @(negedge clk);
        check("cmd_rdy_set_wins", cmd_rdy, 1);
        pulse_clr();

        // Inter-byte idle beyond the timeout drops the partial frame.
        send_byte(8'h55, 1'b1, 1'b0, 1'b0);
        send_byte(8'h66, 1'b1, 1'b0, 1'b0);
        hold_rx(1'b1, 300);
        part.delete();
        check("timeout_no_rdy", cmd_rdy, exp_rdy);
        check("timeout_cmd_kept", cmd, exp_cmd);
        send_frame(8'h02, 8'h12, 8'h34, 1'b0);

        // Framing error on byte 1 discards the frame.
        send_byte(8'h11, 1'b1, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b0);
        hold_rx(1'b1, 2 * BAUD);
        check("ferr_no_rdy", cmd_rdy, exp_rdy);
        check("ferr_cmd_kept", cmd, exp_cmd);
        check("ferr_data_kept", data, exp_data);
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

        // Response transmitter, with a request during the byte that must be ignored.
        tx_byte(8'hA5, 1'b1);
        hold_rx(1'b1, 5);
        tx_byte(8'($urandom), 1'b0);

        // Random frames with short gaps and optional consumer acknowledges.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 3; k++) begin
                send_byte(8'($urandom), 1'b1, k == 2, 1'b0);
                if (k < 2) hold_rx(1'b1, int'($urandom_range(0, 40)));
            end
            if ($urandom_range(0, 1) == 1) pulse_clr();
            hold_rx(1'b1, int'($urandom_range(1, 30)));
        end

        // Receive and transmit at the same time.
        fork
            tx_byte(8'($urandom), 1'b0);
            send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        join

        // Reset in the middle of a frame.
        send_byte(8'h77, 1'b1, 1'b0, 1'b0);
        hold_rx(1'b0, BAUD);
        hold_rx(1'b1, BAUD);
        hold_rx(1'b0, 5);
        rst = 1'b1;
        RX = 1'b1;
        @(negedge clk);
        part.delete();
        exp_cmd = 8'h00;
        exp_data = 16'h0000;
        exp_rdy = 1'b0;
        check("midrst_tx", TX, 1);
        check("midrst_cmd", cmd, exp_cmd);
        check("midrst_data", data, exp_data);
        check("midrst_cmd_rdy", cmd_rdy, exp_rdy);
        check("midrst_tx_busy", tx_busy, 0);
        check("midrst_resp_sent", resp_sent, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold_rx(1'b1, 3 * BAUD);
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
